// File: rtl/mgr_wu_mem_pkg.sv
// mgr_wu_mem_pkg
// Shared types and defaults for the manager WU memory.
//   wu_entry_t       : one WU entry (icntl, dcntl, op, option types, option values)
//   wu_op_e          : instruction type encodings
//   wu_entry_width() : bit width of one wu_entry_t
// Option i lives at index i of the packed option arrays, i.e. at bits
// [i*W +: W] of the flattened option field.
package mgr_wu_mem_pkg;

  localparam int WU_NUM_OPT     = 3;
  localparam int WU_OPT_TYPE_W  = 8;
  localparam int WU_OPT_VALUE_W = 16;
  localparam int WU_CNTL_W      = 2;
  localparam int WU_OP_W        = 2;

  typedef enum logic [WU_OP_W-1:0] {
    WU_NOP = 2'd0,
    WU_OP  = 2'd1,
    WU_MR  = 2'd2,
    WU_MW  = 2'd3
  } wu_op_e;

  typedef struct packed {
    logic [WU_CNTL_W-1:0]                         icntl;
    logic [WU_CNTL_W-1:0]                         dcntl;
    logic [WU_OP_W-1:0]                           op;
    logic [WU_NUM_OPT-1:0][WU_OPT_TYPE_W-1:0]     option_type;
    logic [WU_NUM_OPT-1:0][WU_OPT_VALUE_W-1:0]    option_value;
  } wu_entry_t;

  function automatic int wu_entry_width();
    return $bits(wu_entry_t);
  endfunction

endpackage

// File: rtl/mgr_wu_obuf.sv
// mgr_wu_obuf
// Show-ahead FIFO: the head entry is presented on dout whenever valid=1.
//   clk, reset : clock, synchronous active-high reset (pointers/count only)
//   push, din  : write one entry (caller guarantees free space)
//   pop        : consume the head; ignored while valid=0
//   valid      : FIFO not empty
//   dout       : head entry, forced to zero while empty
//   count      : number of stored entries
module mgr_wu_obuf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic                       valid,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid  = (count != '0);
  assign do_pop = pop && valid;
  assign dout   = valid ? store[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_next(wr_ptr);
      if (do_pop) rd_ptr <= ptr_next(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; stale slots are never visible because dout is masked.
  always_ff @(posedge clk) begin
    if (push) store[wr_ptr] <= din;
  end

  // The upstream credit rule must make a push into a full FIFO impossible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && !do_pop && (count == CNT_W'(DEPTH))));
    end
  end

endmodule

// File: rtl/mgr_wu_memory.sv
// mgr_wu_memory
// WU instruction/descriptor store between WU fetch (wuf) and WU decode (wud).
// Loaded at run time from the manager load path (ld__wum__*).
//   clk, reset_poweron      : clock, synchronous active-high reset
//   ld__wum__*              : write strobe, address and entry fields
//   wuf__wum__read/addr     : read request; wum__wuf__ready grants it
//   wum__wud__valid/ready   : output handshake towards decode
//   wum__wud__*             : output entry fields (head of output buffer)
//   wum__sys__err           : one-cycle error pulse
// Handshakes: a transfer happens in a cycle where both valid (read/valid)
// and ready are 1; the requester holds its request until it is granted,
// and the output entry holds stable while valid=1 and ready=0.
// Read timing: accepted at T, array read registered at T+1 edge, entry
// pushed into the output buffer and visible at T+2.
// Optional build macro: MGR_WU_MEM_PARITY_EN adds an even-parity bit per
// entry, checked when the read data is pushed into the output buffer.
module mgr_wu_memory
  import mgr_wu_mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int NUM_OPT     = WU_NUM_OPT,
  parameter int OPT_TYPE_W  = WU_OPT_TYPE_W,
  parameter int OPT_VALUE_W = WU_OPT_VALUE_W,
  parameter int CNTL_W      = WU_CNTL_W,
  parameter int OP_W        = WU_OP_W,
  parameter int OBUF_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           reset_poweron,
  input  logic                           ld__wum__write,
  input  logic [ADDR_W-1:0]              ld__wum__addr,
  input  logic [CNTL_W-1:0]              ld__wum__icntl,
  input  logic [CNTL_W-1:0]              ld__wum__dcntl,
  input  logic [OP_W-1:0]                ld__wum__op,
  input  logic [NUM_OPT*OPT_TYPE_W-1:0]  ld__wum__option_type,
  input  logic [NUM_OPT*OPT_VALUE_W-1:0] ld__wum__option_value,
  input  logic                           wuf__wum__read,
  input  logic [ADDR_W-1:0]              wuf__wum__addr,
  output logic                           wum__wuf__ready,
  output logic                           wum__wud__valid,
  input  logic                           wud__wum__ready,
  output logic [CNTL_W-1:0]              wum__wud__icntl,
  output logic [CNTL_W-1:0]              wum__wud__dcntl,
  output logic [OP_W-1:0]                wum__wud__op,
  output logic [NUM_OPT*OPT_TYPE_W-1:0]  wum__wud__option_type,
  output logic [NUM_OPT*OPT_VALUE_W-1:0] wum__wud__option_value,
  output logic                           wum__sys__err
);

  localparam int ENTRY_W = 2*CNTL_W + OP_W + NUM_OPT*(OPT_TYPE_W + OPT_VALUE_W);
  localparam int CNT_W   = $clog2(OBUF_DEPTH + 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] wdata;
  logic               wr_in_range;
  logic               rd_in_range;
  logic               wr_en;
  logic               wr_err;
  logic               rd_acc;

  logic               s1_valid;
  logic               s1_oor;
  logic [ENTRY_W-1:0] s1_data;
  logic               par_err;

  logic               obuf_valid;
  logic [ENTRY_W-1:0] obuf_dout;
  logic [CNT_W-1:0]   obuf_count;

  assign wdata = {ld__wum__icntl, ld__wum__dcntl, ld__wum__op,
                  ld__wum__option_type, ld__wum__option_value};

  assign wr_in_range = int'(ld__wum__addr) < DEPTH;
  assign rd_in_range = int'(wuf__wum__addr) < DEPTH;
  assign wr_en       = !reset_poweron && ld__wum__write && wr_in_range;
  assign wr_err      = !reset_poweron && ld__wum__write && !wr_in_range;

  // Credit: buffered entries plus the read in flight must leave a free slot.
  assign wum__wuf__ready = !reset_poweron &&
                           ((int'(obuf_count) + int'(s1_valid)) < OBUF_DEPTH);
  assign rd_acc = wuf__wum__read && wum__wuf__ready;

  // Array is never reset; contents survive reset_poweron.
  always_ff @(posedge clk) begin
    if (wr_en) mem[ld__wum__addr] <= wdata;
  end

  // Reading in the acceptance cycle with non-blocking updates gives
  // read-before-write on a same-address collision.
  always_ff @(posedge clk) begin
    if (rd_acc) begin
      s1_oor  <= !rd_in_range;
      s1_data <= rd_in_range ? mem[wuf__wum__addr] : '0;
    end
  end

`ifdef MGR_WU_MEM_PARITY_EN
  logic mem_par [DEPTH];
  logic s1_par;

  always_ff @(posedge clk) begin
    if (wr_en) mem_par[ld__wum__addr] <= ^wdata;
    if (rd_acc) s1_par <= rd_in_range ? mem_par[wuf__wum__addr] : 1'b0;
  end

  assign par_err = s1_valid && !s1_oor && ((^s1_data) != s1_par);
`else
  assign par_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      s1_valid      <= 1'b0;
      wum__sys__err <= 1'b0;
    end else begin
      s1_valid      <= rd_acc;
      // A single register merges coincident write and read errors.
      wum__sys__err <= wr_err || (s1_valid && s1_oor) || par_err;
    end
  end

  mgr_wu_obuf #(
    .WIDTH (ENTRY_W),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk   (clk),
    .reset (reset_poweron),
    .push  (s1_valid),
    .din   (s1_data),
    .pop   (wud__wum__ready),
    .valid (obuf_valid),
    .dout  (obuf_dout),
    .count (obuf_count)
  );

  assign wum__wud__valid = obuf_valid;
  assign {wum__wud__icntl, wum__wud__dcntl, wum__wud__op,
          wum__wud__option_type, wum__wud__option_value} = obuf_dout;

endmodule

// File: tb/tb_mgr_wu_memory.sv
// tb_mgr_wu_memory
// Bench for mgr_wu_memory built with DEPTH=200 so that addresses 200..255
// are out of range. A reference model (array + queue of accepted reads
// tagged with their acceptance cycle) predicts ready/valid/data/err each
// cycle; directed scenarios add literal expectations.
module tb_mgr_wu_memory;
  import mgr_wu_mem_pkg::*;

  localparam int DEPTH = 200;
  localparam int AW    = 8;
  localparam int NO    = 3;
  localparam int TW    = 8;
  localparam int VW    = 16;
  localparam int CW    = 2;
  localparam int OW    = 2;
  localparam int OBD   = 4;
  localparam int EW    = 2*CW + OW + NO*(TW + VW);

  // clock / reset
  logic clk = 1'b0;
  logic reset_poweron = 1'b1;
  always #5 clk = ~clk;

  logic              ld_write = 1'b0;
  logic [AW-1:0]     ld_addr = '0;
  logic [CW-1:0]     ld_icntl = '0;
  logic [CW-1:0]     ld_dcntl = '0;
  logic [OW-1:0]     ld_op = '0;
  logic [NO*TW-1:0]  ld_otype = '0;
  logic [NO*VW-1:0]  ld_oval = '0;
  logic              rd = 1'b0;
  logic [AW-1:0]     raddr = '0;
  logic              wud_ready = 1'b0;
  logic              wuf_ready;
  logic              valid;
  logic [CW-1:0]     o_icntl;
  logic [CW-1:0]     o_dcntl;
  logic [OW-1:0]     o_op;
  logic [NO*TW-1:0]  o_otype;
  logic [NO*VW-1:0]  o_oval;
  logic              err;

  mgr_wu_memory #(
    .DEPTH(DEPTH), .ADDR_W(AW), .NUM_OPT(NO), .OPT_TYPE_W(TW),
    .OPT_VALUE_W(VW), .CNTL_W(CW), .OP_W(OW), .OBUF_DEPTH(OBD)
  ) dut (
    .clk                    (clk),
    .reset_poweron          (reset_poweron),
    .ld__wum__write         (ld_write),
    .ld__wum__addr          (ld_addr),
    .ld__wum__icntl         (ld_icntl),
    .ld__wum__dcntl         (ld_dcntl),
    .ld__wum__op            (ld_op),
    .ld__wum__option_type   (ld_otype),
    .ld__wum__option_value  (ld_oval),
    .wuf__wum__read         (rd),
    .wuf__wum__addr         (raddr),
    .wum__wuf__ready        (wuf_ready),
    .wum__wud__valid        (valid),
    .wud__wum__ready        (wud_ready),
    .wum__wud__icntl        (o_icntl),
    .wum__wud__dcntl        (o_dcntl),
    .wum__wud__op           (o_op),
    .wum__wud__option_type  (o_otype),
    .wum__wud__option_value (o_oval),
    .wum__sys__err          (err)
  );

  // scoreboard / model state
  typedef struct {
    logic [EW-1:0] data;
    int            acc;
  } rd_t;

  rd_t           exp_q[$];
  logic [EW-1:0] m_mem [256];
  bit            flip_m [256];
  bit            err_at [int];
  int            cyc   = 0;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d act=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: compare outputs against the model, advance the model
  // with the inputs currently applied, then move to the next negedge.
  task automatic cycle();
    logic          exp_ready;
    logic          exp_valid;
    logic          exp_err;
    logic [EW-1:0] rdata;
    logic [EW-1:0] wd;
    rd_t           e;
    #1;
    if (reset_poweron) begin
      exp_ready = 1'b0;
      exp_valid = 1'b0;
      chk("ready_in_reset", EW'(wuf_ready), EW'(1'b0));
    end else begin
      exp_ready = exp_q.size() < OBD;
      exp_valid = (exp_q.size() > 0) && (exp_q[0].acc <= cyc - 2);
      exp_err   = err_at.exists(cyc);
      chk("ready", EW'(wuf_ready), EW'(exp_ready));
      chk("valid", EW'(valid), EW'(exp_valid));
      chk("err", EW'(err), EW'(exp_err));
      if (exp_valid)
        chk("data", {o_icntl, o_dcntl, o_op, o_otype, o_oval}, exp_q[0].data);
    end
    if (reset_poweron) begin
      exp_q.delete();
      err_at.delete();
    end else begin
      if (exp_valid && wud_ready) void'(exp_q.pop_front());
      if (rd && exp_ready) begin
        rdata = (int'(raddr) < DEPTH) ? m_mem[raddr] : '0;
        e.data = rdata;
        e.acc  = cyc;
        exp_q.push_back(e);
        if (int'(raddr) >= DEPTH || flip_m[raddr]) err_at[cyc + 2] = 1'b1;
      end
      if (ld_write) begin
        wd = {ld_icntl, ld_dcntl, ld_op, ld_otype, ld_oval};
        if (int'(ld_addr) < DEPTH) begin
          m_mem[ld_addr]  = wd;
          flip_m[ld_addr] = 1'b0;
        end else begin
          err_at[cyc + 1] = 1'b1;
        end
      end
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic set_wr(input int a, input logic [15:0] v0, input logic [OW-1:0] op);
    ld_write = 1'b1;
    ld_addr  = AW'(a);
    ld_icntl = CW'($urandom_range(0, 3));
    ld_dcntl = CW'($urandom_range(0, 3));
    ld_op    = op;
    ld_otype = NO*TW'({$urandom, $urandom});
    ld_oval  = {32'($urandom), v0};
  endtask

  task automatic idle();
    ld_write  = 1'b0;
    rd        = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) flip_m[i] = 1'b0;
    idle();
    reset_poweron = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cycle();
    reset_poweron = 1'b0;
    #1;
    chk("post_reset_valid", EW'(valid), EW'(1'b0));
    chk("post_reset_err", EW'(err), EW'(1'b0));
    chk("post_reset_ready", EW'(wuf_ready), EW'(1'b1));

    // fill the whole array, then the plan entries
    for (int a = 0; a < DEPTH; a++) begin
      set_wr(a, 16'($urandom), OW'($urandom_range(0, 3)));
      cycle();
    end
    for (int a = 0; a < 4; a++) begin
      set_wr(a, 16'(16'h1000 + a), WU_OP);
      cycle();
    end
    set_wr(5, 16'h5555, WU_OP);
    cycle();
    idle();

    // single read of addr 2: visible two cycles after acceptance
    wud_ready = 1'b1;
    rd = 1'b1; raddr = 8'd2;
    cycle();
    rd = 1'b0;
    chk("lat_t1_valid", EW'(valid), EW'(1'b0));
    cycle();
    chk("lat_t2_valid", EW'(valid), EW'(1'b1));
    chk("lat_t2_op", EW'(o_op), EW'(2'd1));
    chk("lat_t2_ov0", EW'(o_oval[15:0]), EW'(16'h1002));
    chk("lat_t2_err", EW'(err), EW'(1'b0));
    cycle();

    // back-pressure: four reads fill the credit, a fifth is ignored
    wud_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd = 1'b1; raddr = AW'(k);
      cycle();
    end
    rd = 1'b1; raddr = 8'd0;
    chk("bp_ready_low0", EW'(wuf_ready), EW'(1'b0));
    cycle();
    chk("bp_ready_low1", EW'(wuf_ready), EW'(1'b0));
    cycle();
    rd = 1'b0;
    wud_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", EW'(valid), EW'(1'b1));
      chk("drain_ov0", EW'(o_oval[15:0]), EW'(16'h1000 + k));
      cycle();
    end
    chk("drain_empty", EW'(valid), EW'(1'b0));

    // read/write collision on addr 5
    set_wr(5, 16'hAAAA, WU_OP);
    rd = 1'b1; raddr = 8'd5;
    cycle();
    ld_write = 1'b0;
    cycle();
    rd = 1'b0;
    chk("coll_old", EW'(o_oval[15:0]), EW'(16'h5555));
    cycle();
    chk("coll_new_valid", EW'(valid), EW'(1'b1));
    chk("coll_new", EW'(o_oval[15:0]), EW'(16'hAAAA));
    cycle();

    // out-of-range read and write
    rd = 1'b1; raddr = 8'd250;
    cycle();
    rd = 1'b0;
    chk("oor_rd_t1_err", EW'(err), EW'(1'b0));
    cycle();
    chk("oor_rd_valid", EW'(valid), EW'(1'b1));
    chk("oor_rd_data", {o_icntl, o_dcntl, o_op, o_otype, o_oval}, '0);
    chk("oor_rd_err", EW'(err), EW'(1'b1));
    cycle();
    set_wr(200, 16'h1234, WU_MW);
    cycle();
    ld_write = 1'b0;
    chk("oor_wr_err", EW'(err), EW'(1'b1));
    cycle();
    chk("oor_wr_err_end", EW'(err), EW'(1'b0));

    // reset with three entries buffered and one in flight
    wud_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rd = 1'b1; raddr = AW'(k);
      cycle();
    end
    rd = 1'b0;
    reset_poweron = 1'b1;
    cycle();
    chk("mid_reset_valid", EW'(valid), EW'(1'b0));
    reset_poweron = 1'b0;
    cycle();
    wud_ready = 1'b1;
    rd = 1'b1; raddr = 8'd0;
    cycle();
    rd = 1'b0;
    cycle();
    chk("after_reset_ov0", EW'(o_oval[15:0]), EW'(16'h1000));
    cycle();

`ifdef MGR_WU_MEM_PARITY_EN
    dut.mem_par[3] = ~dut.mem_par[3];
    flip_m[3] = 1'b1;
    rd = 1'b1; raddr = 8'd3;
    cycle();
    rd = 1'b0;
    cycle();
    chk("par_valid", EW'(valid), EW'(1'b1));
    chk("par_ov0", EW'(o_oval[15:0]), EW'(16'h1003));
    chk("par_err", EW'(err), EW'(1'b1));
    cycle();
`endif

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      reset_poweron = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 2) == 0)
        set_wr($urandom_range(0, 255), 16'($urandom), OW'($urandom_range(0, 3)));
      else
        ld_write = 1'b0;
      rd        = ($urandom_range(0, 9) < 7);
      raddr     = AW'($urandom_range(0, 255));
      wud_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    reset_poweron = 1'b0;
    idle();
    wud_ready = 1'b1;
    for (int n = 0; n < 8; n++) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mgr_wu_memory.md
Name: mgr_wu_memory

Overview:
- Parametrised, synthesizable WU instruction/descriptor store for the manager, placed between WU fetch (wuf) and WU decode (wud).
- Loaded at run time through a write port from the manager load path (ld); no file-based initialisation.
- Serves pipelined reads with a valid/ready handshake on both sides.
- An internal output buffer absorbs decode back-pressure without losing in-flight reads.

Parameters:
DEPTH, 256, number of WU entries; need not be a power of two
ADDR_W, 8, address width; must satisfy 2^ADDR_W >= DEPTH
NUM_OPT, 3, option (type, value) pairs per entry
OPT_TYPE_W, 8, width of each option type
OPT_VALUE_W, 16, width of each option value
CNTL_W, 2, icntl/dcntl delineator width
OP_W, 2, instruction type width (NOP, OP, MR, MW)
OBUF_DEPTH, 4, output buffer entries; minimum 2

Ports:
clk  in  1  clock
reset_poweron  in  1  synchronous active-high reset
ld__wum__write  in  1  write strobe
ld__wum__addr  in  ADDR_W  write address
ld__wum__icntl  in  CNTL_W  write data, instruction delineator
ld__wum__dcntl  in  CNTL_W  write data, descriptor delineator
ld__wum__op  in  OP_W  write data, instruction type
ld__wum__option_type  in  NUM_OPT*OPT_TYPE_W  write data; option i occupies bits [i*OPT_TYPE_W +: OPT_TYPE_W]
ld__wum__option_value  in  NUM_OPT*OPT_VALUE_W  write data, packed the same way
wuf__wum__read  in  1  read request
wuf__wum__addr  in  ADDR_W  read address
wum__wuf__ready  out  1  read request may be accepted this cycle
wum__wud__valid  out  1  output entry valid
wud__wum__ready  in  1  decode accepts the output entry
wum__wud__icntl  out  CNTL_W  output instruction delineator
wum__wud__dcntl  out  CNTL_W  output descriptor delineator
wum__wud__op  out  OP_W  output instruction type
wum__wud__option_type  out  NUM_OPT*OPT_TYPE_W  output option types
wum__wud__option_value  out  NUM_OPT*OPT_VALUE_W  output option values
wum__sys__err  out  1  one-cycle error pulse

Behaviour:
- Clock and reset: single clock clk; reset_poweron is synchronous and active-high.
- Reset values:
  - wum__wud__valid=0, all wum__wud__* data outputs=0, wum__sys__err=0, wum__wuf__ready=0 during reset.
  - Output buffer pointers and count=0; pipeline valid bits=0.
  - Array contents are not reset.
- Write path:
  - Write occurs when ld__wum__write=1 and not in reset.
  - Write with addr >= DEPTH is dropped and pulses wum__sys__err the next cycle.
- Read acceptance:
  - A read is accepted when wuf__wum__read and wum__wuf__ready are both 1.
  - wum__wuf__ready = (count + inflight) < OBUF_DEPTH, where inflight counts reads in stages S1/S2.
  - A read issued while ready=0 is ignored; wuf holds the request.
- Pipeline:
  - Cycle T: read accepted.
  - S1 (T+1): registered address, array read.
  - S2 (T+2): registered data written into the output buffer.
  - Empty buffer: wum__wud__valid=1 at T+2 (latency 2). Back-to-back reads give one entry per cycle.
- Read with addr >= DEPTH: returns all-zero data with valid=1 and pulses wum__sys__err at T+2.
- Read/write collision (same address, same cycle as acceptance): returns old data (read-before-write).
- Output buffer:
  - FIFO; head is driven directly on the wum__wud__* outputs.
  - Pop on wum__wud__valid & wud__wum__ready.
  - Push and pop in the same cycle leave count unchanged.
  - Output data holds stable while valid=1 and ready=0.
  - Pointers wrap at OBUF_DEPTH.
  - Overflow is impossible by the credit rule; assert-check it.
- Reset mid-operation: in-flight reads and buffered entries are discarded; wum__wud__valid=0 the cycle after reset asserts.
- Error pulses: if a write error and a read error coincide, wum__sys__err is a single 1-cycle pulse.

Optional Feature:
MGR_WU_MEM_PARITY_EN
- Defined:
  - Each entry stores one even-parity bit computed over all fields at write time.
  - Parity is checked at S2.
  - On mismatch, the entry is still delivered and wum__sys__err pulses at T+2.
- Undefined: no parity storage or check; wum__sys__err reports address-range errors only.

Decomposition:
- Shared package mgr_wu_mem_pkg:
  - packed struct wu_entry_t (icntl, dcntl, op, option_type[NUM_OPT], option_value[NUM_OPT]);
  - function wu_entry_width();
  - op encodings NOP/OP/MR/MW.
- One sub-module: mgr_wu_obuf, a parametrised show-ahead FIFO with count output.
- Array and pipeline stay in the top module.

Test Plan:
- Reset, then write entries 0..3 (op=1, option_value0=0x1000+addr). Read addr 2 at T -> valid at T+2, op=1, option_value0=0x1002, err=0.
- Four back-to-back reads with wud__wum__ready=0:
  - -> wum__wuf__ready=0 once count+inflight=4; a fifth request is ignored.
  - Release ready -> entries drain in order 0,1,2,3, one per cycle.
- Write 0xAAAA to addr 5 and read addr 5 in the same cycle (old value 0x5555) -> output 0x5555; a following read returns 0xAAAA.
- DEPTH=200, read addr 250 -> all-zero entry delivered, err pulse at T+2. Write addr 200 -> dropped, err pulse at T+1.
- Assert reset_poweron with 3 entries buffered and 1 in flight -> valid=0 next cycle. After reset release, a read of addr 0 still returns the pre-reset contents.
- With MGR_WU_MEM_PARITY_EN: force a stored parity bit flip via backdoor, read that entry -> data delivered, err=1 at T+2.
